fib_seq_ctrl: RTL and testbench

//   Sequential Fibonacci term generator/controller. A start command latches two

---
 rtl/fib_seq_ctrl.sv | 122 ++++++++++++
 tb/tb_fib_seq_ctrl.sv | 437 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fib_seq_ctrl.sv
// fib_seq_ctrl: clocked Fibonacci term streamer with a valid/ready output port.
// A start command in IDLE latches two seeds and a (clamped) term count. Terms
// are then offered one at a time; each accepted handshake advances the series.
module fib_seq_ctrl #(
    parameter  int unsigned WIDTH     = 32,
    parameter  int unsigned MAX_TERMS = 64,
    localparam int unsigned CNT_W     = $clog2(MAX_TERMS + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] seed1,
    input  logic [WIDTH-1:0] seed2,
    input  logic [CNT_W-1:0] num_terms,
    output logic             busy,
    output logic             term_valid,
    input  logic             term_ready,
    output logic [WIDTH-1:0] term_data,
    output logic [CNT_W-1:0] term_idx,
    output logic             done,
    output logic             overflow
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EMIT = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_a;      // term currently offered
    logic [WIDTH-1:0] r_b;      // lookahead term
    logic             r_wa;     // r_a has wrapped at some point in its history
    logic             r_wb;     // r_b has wrapped at some point in its history
    logic [CNT_W-1:0] r_idx;
    logic [CNT_W-1:0] r_n;

    logic [WIDTH:0]   w_sum;
    logic             w_xfer;
    logic             w_last;
    logic [CNT_W-1:0] w_n_clamp;

    // Next-term sum with carry, handshake, last-term and count clamp decode
    assign w_sum     = {1'b0, r_a} + {1'b0, r_b};
    assign w_xfer    = term_valid && term_ready;
    assign w_last    = (r_idx == (r_n - CNT_W'(1)));
    assign w_n_clamp = (num_terms > CNT_W'(MAX_TERMS)) ? CNT_W'(MAX_TERMS) : num_terms;

    // Controller: state, series registers and all registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_a        <= '0;
            r_b        <= '0;
            r_wa       <= 1'b0;
            r_wb       <= 1'b0;
            r_idx      <= '0;
            r_n        <= '0;
            busy       <= 1'b0;
            term_valid <= 1'b0;
            term_data  <= '0;
            term_idx   <= '0;
            done       <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_a      <= seed1;
                        r_b      <= seed2;
                        r_wa     <= 1'b0;
                        r_wb     <= 1'b0;
                        r_idx    <= '0;
                        r_n      <= w_n_clamp;
                        overflow <= 1'b0;
                        term_idx <= '0;
                        if (w_n_clamp == '0) begin
                            // Empty request: straight to the done pulse
                            r_state <= S_DONE;
                            done    <= 1'b1;
                            busy    <= 1'b0;
                        end else begin
                            r_state    <= S_EMIT;
                            busy       <= 1'b1;
                            term_valid <= 1'b1;
                            term_data  <= seed1;
                        end
                    end
                end
                S_EMIT: begin
                    if (w_xfer) begin
                        // Only the term just handed over can raise overflow
                        overflow <= overflow | r_wa;
                        r_a      <= r_b;
                        r_wa     <= r_wb;
                        r_b      <= w_sum[WIDTH-1:0];
                        r_wb     <= w_sum[WIDTH] | r_wa | r_wb;
                        r_idx    <= r_idx + CNT_W'(1);
                        if (w_last) begin
                            r_state    <= S_DONE;
                            term_valid <= 1'b0;
                            done       <= 1'b1;
                            busy       <= 1'b0;
                        end else begin
                            term_data <= r_b;
                            term_idx  <= r_idx + CNT_W'(1);
                        end
                    end
                end
                S_DONE: begin
                    // Starts seen here are dropped; a new command needs IDLE
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fib_seq_ctrl.sv
// tb_fib_seq_ctrl: randomized and directed bench for fib_seq_ctrl (8-bit terms).
module tb_fib_seq_ctrl;

    localparam int unsigned WIDTH     = 8;
    localparam int unsigned MAX_TERMS = 64;
    localparam int unsigned CNT_W     = $clog2(MAX_TERMS + 1);

    logic             clk = 1'b0;
    logic             rst_n;
    logic             start;
    logic [WIDTH-1:0] seed1;
    logic [WIDTH-1:0] seed2;
    logic [CNT_W-1:0] num_terms;
    logic             busy;
    logic             term_valid;
    logic             term_ready;
    logic [WIDTH-1:0] term_data;
    logic [CNT_W-1:0] term_idx;
    logic             done;
    logic             overflow;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference results
    logic [WIDTH-1:0] exp_data[$];
    bit               exp_ovf;

    // Observed results of one run
    logic [WIDTH-1:0] got_data[$];
    int               got_idx[$];
    bit               got_done;
    int               got_gap;
    int               got_hold_err;
    int               got_busy_err;
    logic             got_ovf_start;
    logic             got_ovf_pre_last;

    always #5 clk = ~clk;

    fib_seq_ctrl #(
        .WIDTH     (WIDTH),
        .MAX_TERMS (MAX_TERMS)
    ) u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .seed1      (seed1),
        .seed2      (seed2),
        .num_terms  (num_terms),
        .busy       (busy),
        .term_valid (term_valid),
        .term_ready (term_ready),
        .term_data  (term_data),
        .term_idx   (term_idx),
        .done       (done),
        .overflow   (overflow)
    );

    // Series from the rules: exact integer terms, reduced mod 2**WIDTH on output
    function automatic void model_seq(input int s1, input int s2, input int n);
        longint unsigned t_cur;
        longint unsigned t_nxt;
        longint unsigned t_tmp;
        longint unsigned lim;
        int              cnt;
        lim = longint'(1) << WIDTH;
        cnt = (n > int'(MAX_TERMS)) ? int'(MAX_TERMS) : n;
        exp_data.delete();
        exp_ovf = 1'b0;
        t_cur = longint'(s1);
        t_nxt = longint'(s2);
        for (int i = 0; i < cnt; i++) begin
            exp_data.push_back(WIDTH'(t_cur % lim));
            if (t_cur >= lim) exp_ovf = 1'b1;
            t_tmp = t_cur + t_nxt;
            t_cur = t_nxt;
            t_nxt = t_tmp;
        end
    endfunction

    // Issue a start, then act as consumer until done (mode 0: ready=1, 1: toggle, 2: random)
    task automatic run_seq(input int s1, input int s2, input int n, input int mode, input bit inject);
        logic [WIDTH-1:0] prev_data;
        int               prev_idx;
        bit               prev_stall;
        int               last_x;
        got_data.delete();
        got_idx.delete();
        got_done         = 1'b0;
        got_gap          = -99;
        got_hold_err     = 0;
        got_busy_err     = 0;
        got_ovf_pre_last = 1'bx;
        @(negedge clk);
        start     = 1'b1;
        seed1     = WIDTH'(s1);
        seed2     = WIDTH'(s2);
        num_terms = CNT_W'(n);
        @(negedge clk);
        start     = 1'b0;
        seed1     = WIDTH'($urandom);
        seed2     = WIDTH'($urandom);
        num_terms = CNT_W'($urandom);
        got_ovf_start = overflow;
        prev_stall = 1'b0;
        prev_data  = '0;
        prev_idx   = 0;
        last_x     = -1;
        for (int cyc = 0; cyc < 600; cyc++) begin
            if (done === 1'b1) begin
                got_done = 1'b1;
                got_gap  = cyc - last_x;
                break;
            end
            if (inject && cyc == 2) begin
                start     = 1'b1;
                seed1     = WIDTH'(5);
                seed2     = WIDTH'(5);
                num_terms = CNT_W'(3);
            end else if (inject && cyc == 3) begin
                start = 1'b0;
            end
            if (prev_stall) begin
                if (term_valid !== 1'b1 || term_data !== prev_data || int'(term_idx) != prev_idx)
                    got_hold_err++;
            end
            if (term_valid === 1'b1 && busy !== 1'b1) got_busy_err++;
            case (mode)
                0:       term_ready = 1'b1;
                1:       term_ready = (cyc % 2 == 0);
                default: term_ready = 1'($urandom_range(0, 1));
            endcase
            if (term_valid === 1'b1 && term_ready) begin
                got_data.push_back(term_data);
                got_idx.push_back(int'(term_idx));
                got_ovf_pre_last = overflow;
                last_x     = cyc;
                prev_stall = 1'b0;
            end else begin
                prev_stall = (term_valid === 1'b1);
            end
            prev_data = term_data;
            prev_idx  = int'(term_idx);
            @(negedge clk);
        end
        term_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start = 1'b0; seed1 = '0; seed2 = '0; num_terms = '0; term_ready = 1'b0;
        repeat (3) @(negedge clk);
        n_tests++;
        if ({busy, term_valid, done, overflow} !== 4'b0000 || term_data !== '0 || term_idx !== '0) begin
            n_fail++;
            $display("FAIL reset_values: got busy=%b valid=%b done=%b ovf=%b data=%0d idx=%0d, expected all 0",
                     busy, term_valid, done, overflow, term_data, term_idx);
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        n_tests++;
        if ({busy, term_valid, done, overflow} !== 4'b0000) begin
            n_fail++;
            $display("FAIL idle_after_reset: got busy=%b valid=%b done=%b ovf=%b, expected 0000",
                     busy, term_valid, done, overflow);
        end
    endtask

    task automatic test_stream();
        int ref1[10] = '{0, 1, 1, 2, 3, 5, 8, 13, 21, 34};
        run_seq(0, 1, 10, 0, 1'b0);
        n_tests++;
        if (got_data.size() != 10) begin
            n_fail++;
            $display("FAIL stream_count: got %0d transfers, expected 10", got_data.size());
        end
        for (int i = 0; i < 10 && i < got_data.size(); i++) begin
            n_tests++;
            if (int'(got_data[i]) != ref1[i] || got_idx[i] != i) begin
                n_fail++;
                $display("FAIL stream_term%0d: got data=%0d idx=%0d, expected data=%0d idx=%0d",
                         i, got_data[i], got_idx[i], ref1[i], i);
            end
        end
        n_tests++;
        if (!got_done || got_gap != 1 || overflow !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL stream_done: got done=%0d gap=%0d ovf=%b busy=%b, expected 1 1 0 0",
                     got_done, got_gap, overflow, busy);
        end
        @(negedge clk);
        n_tests++;
        if (done !== 1'b0 || term_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL done_width: got done=%b valid=%b one cycle later, expected 0 0", done, term_valid);
        end
    endtask

    task automatic test_backpressure();
        int ref2[6] = '{2, 1, 3, 4, 7, 11};
        run_seq(2, 1, 6, 1, 1'b0);
        n_tests++;
        if (got_data.size() != 6 || got_hold_err != 0 || got_busy_err != 0) begin
            n_fail++;
            $display("FAIL bp_flow: got transfers=%0d hold_err=%0d busy_err=%0d, expected 6 0 0",
                     got_data.size(), got_hold_err, got_busy_err);
        end
        for (int i = 0; i < 6 && i < got_data.size(); i++) begin
            n_tests++;
            if (int'(got_data[i]) != ref2[i] || got_idx[i] != i) begin
                n_fail++;
                $display("FAIL bp_term%0d: got data=%0d idx=%0d, expected data=%0d idx=%0d",
                         i, got_data[i], got_idx[i], ref2[i], i);
            end
        end
        n_tests++;
        if (!got_done || got_gap != 1) begin
            n_fail++;
            $display("FAIL bp_done: got done=%0d gap=%0d, expected 1 1", got_done, got_gap);
        end
    endtask

    task automatic test_zero_one();
        run_seq(7, 9, 0, 0, 1'b0);
        n_tests++;
        if (got_data.size() != 0 || !got_done || got_gap != 1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL n0: got transfers=%0d done=%0d gap=%0d busy=%b, expected 0 1 1 0",
                     got_data.size(), got_done, got_gap, busy);
        end
        run_seq(7, 9, 1, 2, 1'b0);
        n_tests++;
        if (got_data.size() != 1 || got_data[0] !== 8'd7 || !got_done || got_gap != 1) begin
            n_fail++;
            $display("FAIL n1: got transfers=%0d first=%0d done=%0d gap=%0d, expected 1 7 1 1",
                     got_data.size(), (got_data.size() > 0) ? int'(got_data[0]) : -1, got_done, got_gap);
        end
        run_seq(7, 9, 2, 0, 1'b0);
        n_tests++;
        if (got_data.size() != 2 || got_data[0] !== 8'd7 || got_data[1] !== 8'd9) begin
            n_fail++;
            $display("FAIL n2: got transfers=%0d, expected 2 terms 7,9", got_data.size());
        end
    endtask

    task automatic test_wrap();
        run_seq(0, 1, 14, 2, 1'b0);
        n_tests++;
        if (got_data.size() != 14 || got_data[got_data.size()-1] !== 8'd233 || overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL wrap_n14: got transfers=%0d last=%0d ovf=%b, expected 14 233 0",
                     got_data.size(), got_data[got_data.size()-1], overflow);
        end
        run_seq(0, 1, 15, 2, 1'b0);
        n_tests++;
        if (got_data.size() != 15 || got_data[got_data.size()-1] !== 8'd121) begin
            n_fail++;
            $display("FAIL wrap_n15_last: got transfers=%0d last=%0d, expected 15 121",
                     got_data.size(), got_data[got_data.size()-1]);
        end
        n_tests++;
        if (got_ovf_pre_last !== 1'b0 || overflow !== 1'b1) begin
            n_fail++;
            $display("FAIL wrap_n15_ovf: got before_last=%b after=%b, expected 0 1", got_ovf_pre_last, overflow);
        end
        repeat (3) @(negedge clk);
        n_tests++;
        if (overflow !== 1'b1) begin
            n_fail++;
            $display("FAIL ovf_sticky: got %b in idle, expected 1", overflow);
        end
        run_seq(0, 1, 3, 0, 1'b0);
        n_tests++;
        if (got_ovf_start !== 1'b0 || overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL ovf_clear: got at_start=%b at_end=%b, expected 0 0", got_ovf_start, overflow);
        end
    endtask

    task automatic test_busy_start();
        model_seq(3, 4, 8);
        run_seq(3, 4, 8, 0, 1'b1);
        n_tests++;
        if (got_data.size() != exp_data.size()) begin
            n_fail++;
            $display("FAIL busy_start_count: got %0d transfers, expected %0d", got_data.size(), exp_data.size());
        end
        for (int i = 0; i < exp_data.size() && i < got_data.size(); i++) begin
            n_tests++;
            if (got_data[i] !== exp_data[i] || got_idx[i] != i) begin
                n_fail++;
                $display("FAIL busy_start_term%0d: got %0d idx %0d, expected %0d idx %0d",
                         i, got_data[i], got_idx[i], exp_data[i], i);
            end
        end
    endtask

    task automatic test_clamp();
        int s1;
        int s2;
        s1 = int'($urandom_range(0, 255));
        s2 = int'($urandom_range(0, 255));
        model_seq(s1, s2, int'(MAX_TERMS) + 5);
        run_seq(s1, s2, int'(MAX_TERMS) + 5, 0, 1'b0);
        n_tests++;
        if (got_data.size() != int'(MAX_TERMS) || got_idx[got_idx.size()-1] != int'(MAX_TERMS) - 1) begin
            n_fail++;
            $display("FAIL clamp_count: got %0d transfers last_idx=%0d, expected %0d %0d",
                     got_data.size(), got_idx[got_idx.size()-1], MAX_TERMS, MAX_TERMS - 1);
        end
        for (int i = 0; i < exp_data.size() && i < got_data.size(); i++) begin
            n_tests++;
            if (got_data[i] !== exp_data[i]) begin
                n_fail++;
                $display("FAIL clamp_term%0d: got %0d, expected %0d", i, got_data[i], exp_data[i]);
            end
        end
        n_tests++;
        if (overflow !== exp_ovf) begin
            n_fail++;
            $display("FAIL clamp_ovf: got %b, expected %b", overflow, exp_ovf);
        end
    endtask

    task automatic test_start_at_done();
        run_seq(2, 3, 3, 0, 1'b0);
        start     = 1'b1;
        seed1     = 8'd9;
        seed2     = 8'd9;
        num_terms = CNT_W'(5);
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < 3; k++) begin
            n_tests++;
            if (term_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
                n_fail++;
                $display("FAIL start_at_done_c%0d: got valid=%b busy=%b done=%b, expected 0 0 0",
                         k, term_valid, busy, done);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        start = 1'b1; seed1 = 8'd200; seed2 = 8'd100; num_terms = CNT_W'(10);
        @(negedge clk);
        start = 1'b0;
        term_ready = 1'b1;
        repeat (3) @(negedge clk);
        term_ready = 1'b0;
        n_tests++;
        if (term_valid !== 1'b1 || term_idx !== CNT_W'(3) || overflow !== 1'b1 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL pre_reset: got valid=%b idx=%0d ovf=%b busy=%b, expected 1 3 1 1",
                     term_valid, term_idx, overflow, busy);
        end
        #2 rst_n = 1'b0;
        #1;
        n_tests++;
        if ({busy, term_valid, done, overflow} !== 4'b0000) begin
            n_fail++;
            $display("FAIL mid_reset: got busy=%b valid=%b done=%b ovf=%b, expected 0000",
                     busy, term_valid, done, overflow);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        n_tests++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL post_reset_idle: got done=%b busy=%b, expected 0 0", done, busy);
        end
        run_seq(1, 1, 4, 0, 1'b0);
        n_tests++;
        if (got_data.size() != 4 || got_data[0] !== 8'd1 || got_data[1] !== 8'd1 ||
            got_data[2] !== 8'd2 || got_data[3] !== 8'd3) begin
            n_fail++;
            $display("FAIL restart_seq: got %0d transfers, expected 1,1,2,3", got_data.size());
        end
    endtask

    task automatic test_random();
        int s1;
        int s2;
        int n;
        int mode;
        int bad;
        for (int it = 0; it < 10; it++) begin
            s1   = int'($urandom_range(0, 255));
            s2   = int'($urandom_range(0, 255));
            n    = int'($urandom_range(0, 24));
            mode = int'($urandom_range(0, 2));
            model_seq(s1, s2, n);
            run_seq(s1, s2, n, mode, 1'b0);
            bad = 0;
            for (int i = 0; i < exp_data.size() && i < got_data.size(); i++)
                if (got_data[i] !== exp_data[i] || got_idx[i] != i) bad++;
            n_tests++;
            if (got_data.size() != exp_data.size() || bad != 0) begin
                n_fail++;
                $display("FAIL rand%0d_terms: seeds %0d,%0d n=%0d got %0d transfers %0d wrong, expected %0d 0",
                         it, s1, s2, n, got_data.size(), bad, exp_data.size());
            end
            n_tests++;
            if (overflow !== exp_ovf || !got_done || got_gap != 1 || got_hold_err != 0 || got_busy_err != 0) begin
                n_fail++;
                $display("FAIL rand%0d_ctrl: got ovf=%b done=%0d gap=%0d hold=%0d busy=%0d, expected %b 1 1 0 0",
                         it, overflow, got_done, got_gap, got_hold_err, got_busy_err, exp_ovf);
            end
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
        $fatal(1);
    end

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_zero_one();
        test_wrap();
        test_busy_start();
        test_clamp();
        test_start_at_done();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
